// File: rtl/stream_upsizer_clearable.sv
// Packs RATIO narrow beats into one wide word behind a single output register.
// A level-sensitive clear flushes both the partial word and any pending output word.
module stream_upsizer_clearable_lane #(
  parameter int IN_WIDTH = 8,
  parameter int CNT_W    = 3,
  parameter int LANE     = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic                complete_i,
  input  logic [CNT_W-1:0]    cnt_i,
  input  logic [IN_WIDTH-1:0] in_data_i,
  output logic [IN_WIDTH-1:0] out_data_o
);
  localparam logic [CNT_W-1:0] IDX = CNT_W'(LANE);

  logic [IN_WIDTH-1:0] asm_q, out_q;
  logic                sel;

  assign sel        = (cnt_i == IDX);
  assign out_data_o = out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q <= '0;
      out_q <= '0;
    end else if (clear_i) begin
      asm_q <= '0;
      out_q <= '0;
    end else begin
      if (complete_i)                 asm_q <= '0;
      else if (accept_i && sel)       asm_q <= in_data_i;
      // Lanes above the closing beat are forced to zero on an early close.
      if (complete_i) begin
        if (sel)                      out_q <= in_data_i;
        else if (IDX < cnt_i)         out_q <= asm_q;
        else                          out_q <= '0;
      end
    end
  end
endmodule

module stream_upsizer_clearable #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0]     out_count_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]                   cnt_q, out_count_q;
  logic                               out_valid_q;
  logic [RATIO-1:0][IN_WIDTH-1:0]     out_lanes;
  logic                               accept, complete, out_fire;

  assign in_ready_o  = !clear_i && (!out_valid_q || out_ready_i);
  assign out_valid_o = out_valid_q && !clear_i;
  assign accept      = in_valid_i && in_ready_o;
  assign complete    = accept && ((cnt_q == LAST_IDX) || in_last_i);
  assign out_fire    = out_valid_o && out_ready_i;

  assign out_data_o  = out_lanes;
  assign out_count_o = out_count_q;
  assign busy_o      = (cnt_q != '0) || out_valid_q;

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    stream_upsizer_clearable_lane #(
      .IN_WIDTH(IN_WIDTH),
      .CNT_W   (CNT_W),
      .LANE    (k)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .accept_i  (accept),
      .complete_i(complete),
      .cnt_i     (cnt_q),
      .in_data_i (in_data_i),
      .out_data_o(out_lanes[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (complete)    cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + CNT_W'(1);
      // A completion in the same cycle as a transfer reloads the register back-to-back.
      if (complete) begin
        out_count_q <= cnt_q + CNT_W'(1);
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_upsizer_clearable.sv
// Directed vector table, hand sequences, and randomized traffic against a queue-based word model.
module tb_stream_upsizer_clearable;
  localparam int IW = 8;
  localparam int R  = 4;
  localparam int OW = IW * R;
  localparam int CW = $clog2(R + 1);

  logic          gclk = 1'b0;
  logic          grst_n;
  logic          clr, vld, lst, ordy;
  logic [IW-1:0] din;
  logic          irdy, oval, busy;
  logic [OW-1:0] dout;
  logic [CW-1:0] ocnt;

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  stream_upsizer_clearable #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk_i      (gclk),
    .rst_ni     (grst_n),
    .clear_i    (clr),
    .in_data_i  (din),
    .in_last_i  (lst),
    .in_valid_i (vld),
    .in_ready_o (irdy),
    .out_data_o (dout),
    .out_count_o(ocnt),
    .out_valid_o(oval),
    .out_ready_i(ordy),
    .busy_o     (busy)
  );

  typedef struct {
    logic          v, l, r, c;
    logic [IW-1:0] d;
    logic          e_rdy, e_val, e_busy;
    logic [OW-1:0] e_data;
    int            e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the partial word is a queue of beats; the output slot is one word.
  logic [IW-1:0] part[$];
  logic          m_ov;
  logic [OW-1:0] m_od;
  int            m_oc;

  task automatic model_reset();
    part.delete();
    m_ov = 1'b0; m_od = '0; m_oc = 0;
  endtask

  function automatic logic model_rdy();
    return !clr && (!m_ov || ordy);
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".in_ready"}, 64'(irdy), 64'(model_rdy()));
    chk({tag, ".out_valid"}, 64'(oval), 64'(m_ov && !clr));
    chk({tag, ".out_data"}, 64'(dout), 64'(m_od));
    chk({tag, ".out_count"}, 64'(ocnt), 64'(m_oc));
    chk({tag, ".busy"}, 64'(busy), 64'((part.size() != 0) || m_ov));
  endtask

  task automatic model_edge();
    logic acc;
    logic [OW-1:0] w;
    if (clr) begin
      model_reset();
      return;
    end
    acc = vld && model_rdy();
    if (m_ov && ordy) m_ov = 1'b0;
    if (acc) begin
      part.push_back(din);
      if (part.size() == R || lst) begin
        w = '0;
        foreach (part[i]) w[i*IW +: IW] = part[i];
        m_od = w; m_oc = part.size(); m_ov = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] d, input logic l,
                       input logic r, input logic c);
    vld = v; din = d; lst = l; ordy = r; clr = c;
  endtask

  vec_t tbl[$];

  task automatic add(input logic v, input logic [IW-1:0] d, input logic l, input logic r,
                     input logic c, input logic er, input logic ev, input logic [OW-1:0] ed,
                     input int ec, input logic eb);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.c = c;
    t.e_rdy = er; t.e_val = ev; t.e_data = ed; t.e_cnt = ec; t.e_busy = eb;
    tbl.push_back(t);
  endtask

  logic [OW-1:0] got[$];
  int            got_at[$];

  initial begin
    grst_n = 1'b0;
    drive(0, '0, 0, 1, 0);
    model_reset();
    #12;
    chk("reset.out_valid", 64'(oval), 64'd0);
    chk("reset.out_data", 64'(dout), 64'd0);
    chk("reset.out_count", 64'(ocnt), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.in_ready", 64'(irdy), 64'd1);
    @(negedge gclk); grst_n = 1'b1;
    @(posedge gclk); #1;

    // v d l r c | rdy val data cnt busy
    add(1, 8'h11, 0, 1, 0, 1, 0, 32'h0, 0, 0);          // full word
    add(1, 8'h22, 0, 1, 0, 1, 0, 32'h0, 0, 1);
    add(1, 8'h33, 0, 1, 0, 1, 0, 32'h0, 0, 1);
    add(1, 8'h44, 0, 1, 0, 1, 0, 32'h0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 1, 32'h44332211, 4, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 32'h44332211, 4, 0);
    add(1, 8'hAA, 0, 1, 0, 1, 0, 32'h44332211, 4, 0);   // early last
    add(1, 8'hBB, 1, 1, 0, 1, 0, 32'h44332211, 4, 1);
    add(0, 8'h00, 0, 1, 0, 1, 1, 32'h0000BBAA, 2, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 32'h0000BBAA, 2, 0);
    add(1, 8'h01, 0, 0, 0, 1, 0, 32'h0000BBAA, 2, 0);   // backpressure
    add(1, 8'h02, 0, 0, 0, 1, 0, 32'h0000BBAA, 2, 1);
    add(1, 8'h03, 0, 0, 0, 1, 0, 32'h0000BBAA, 2, 1);
    add(1, 8'h04, 0, 0, 0, 1, 0, 32'h0000BBAA, 2, 1);
    for (int i = 0; i < 5; i++)
      add(1, 8'h05, 0, 0, 0, 0, 1, 32'h04030201, 4, 1);
    add(1, 8'h05, 0, 1, 0, 1, 1, 32'h04030201, 4, 1);   // transfer + beat 0 together
    add(0, 8'h00, 0, 1, 0, 1, 0, 32'h04030201, 4, 1);
    add(1, 8'h06, 0, 1, 1, 0, 0, 32'h04030201, 4, 1);   // clear mid-assembly
    add(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 0, 0);
    add(1, 8'h11, 0, 0, 0, 1, 0, 32'h0, 0, 0);          // clear with pending word
    add(1, 8'h22, 0, 0, 0, 1, 0, 32'h0, 0, 1);
    add(1, 8'h33, 0, 0, 0, 1, 0, 32'h0, 0, 1);
    add(1, 8'h44, 0, 0, 0, 1, 0, 32'h0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0, 32'h44332211, 4, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].c);
      @(negedge gclk);
      chk($sformatf("vec%0d.in_ready", i), 64'(irdy), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.out_valid", i), 64'(oval), 64'(tbl[i].e_val));
      chk($sformatf("vec%0d.out_data", i), 64'(dout), 64'(tbl[i].e_data));
      chk($sformatf("vec%0d.out_count", i), 64'(ocnt), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
      @(posedge gclk); #1;
    end

    // Back-to-back: 8 beats, no idle input cycle, two consecutive words.
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 8'(i + 1), 0, 1, 0);
      @(negedge gclk);
      if (i < 8) chk("b2b.in_ready", 64'(irdy), 64'd1);
      if (oval && ordy) begin got.push_back(dout); got_at.push_back(i); end
      @(posedge gclk); #1;
    end
    chk("b2b.words", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("b2b.word0", 64'(got[0]), 64'h04030201);
      chk("b2b.word1", 64'(got[1]), 64'h08070605);
      chk("b2b.t0", 64'(got_at[0]), 64'd4);
      chk("b2b.t1", 64'(got_at[1]), 64'd8);
    end

    // Asynchronous reset mid-word discards the partial word and the held output.
    drive(1, 8'hE1, 0, 1, 0); @(posedge gclk); #1;
    drive(1, 8'hE2, 0, 1, 0); @(posedge gclk); #2;
    grst_n = 1'b0; #1;
    chk("arst.out_valid", 64'(oval), 64'd0);
    chk("arst.out_data", 64'(dout), 64'd0);
    chk("arst.out_count", 64'(ocnt), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    drive(0, '0, 0, 1, 0);
    @(negedge gclk); grst_n = 1'b1;
    @(posedge gclk); #1;
    model_reset();

    // Randomized traffic against the word model.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      @(negedge gclk);
      model_check("rand");
      @(posedge gclk);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
